mips_divider: RTL and testbench

Multi-cycle 32-bit integer divider for the MIPS `div`/`divu` path. It is the inverse of the datapath adder: a restoring divider that retires one quotient bit per cycle, using a 32-bit trial subtraction. Quotient feeds LO and remainder feeds HI. A start/busy/done handshake lets the controller stall until results are valid.

---
 rtl/mips_div_pkg.sv | 30 +++
 rtl/adderModule.sv | 23 ++
 rtl/mips_divider.sv | 164 ++++++++++++++++
 tb/tb_mips_divider.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared definitions for the MIPS div/divu multi-cycle divider.
// Provides the FSM state type, datapath widths, the divide-by-zero quotient
// pattern and small two's-complement helpers used when taking operand
// magnitudes and applying result signs.
package mips_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Two's-complement negate.
  function automatic logic [DIV_WIDTH-1:0] neg2(input logic [DIV_WIDTH-1:0] x);
    return (~x) + 32'd1;
  endfunction

  // Magnitude of x when it is to be treated as signed and is negative.
  // 0x80000000 maps to itself, which is what the overflow case relies on.
  function automatic logic [DIV_WIDTH-1:0] mag(input logic [DIV_WIDTH-1:0] x,
                                               input logic                 sgn);
    return (sgn && x[DIV_WIDTH-1]) ? neg2(x) : x;
  endfunction

endpackage

// File: rtl/adderModule.sv
// 32-bit ripple-style adder shared with the datapath.
// Ports: A, B   - addends
//        Cin    - carry in
//        S      - sum
//        cout2  - carry out of bit 31
//        OF     - two's-complement overflow
module adderModule (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        cout2,
  output logic        OF
);

  // Full-width sum with carry out; overflow when same-signed inputs
  // produce a result of the opposite sign.
  always_comb begin
    {cout2, S} = {1'b0, A} + {1'b0, B} + {32'd0, Cin};
    OF         = (A[31] == B[31]) && (S[31] != A[31]);
  end

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for MIPS div/divu.
// One quotient bit per cycle (32 RUN cycles), one FIX cycle to apply signs
// or the divide-by-zero pattern, then a one-cycle done pulse.
// Ports: clk, reset (async, active-high)
//        start, is_signed, dividend, divisor - request, captured in IDLE
//        busy        - high from the cycle after accept through FIX
//        done        - one-cycle result-valid pulse
//        quotient    - LO result, held in a dedicated register
//        remainder   - HI result, held in a dedicated register
//        div_by_zero - captured divisor was zero
module mips_divider
  import mips_div_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  div_state_t               state_r, state_s;
  logic [DIV_CNT_W-1:0]     cnt_r;
  logic [DIV_WIDTH-1:0]     q_r, rem_r, dmag_r, raw_a_r;
  logic                     sign_a_r, sign_b_r, dz_r;

  logic [DIV_WIDTH:0]       shifted_s;
  logic [DIV_WIDTH-1:0]     diff_s;
  logic                     no_borrow_s, take_s;
  logic                     unused_of;
  logic [DIV_WIDTH-1:0]     fix_q_s, fix_r_s;

  // Trial subtraction: shifted remainder minus divisor magnitude.
  adderModule u_trial (
    .A     (shifted_s[DIV_WIDTH-1:0]),
    .B     (~dmag_r),
    .Cin   (1'b1),
    .S     (diff_s),
    .cout2 (no_borrow_s),
    .OF    (unused_of)
  );

  // Shift the next dividend bit into the partial remainder and decide
  // whether the divisor fits; bit 32 set means it fits regardless of carry.
  always_comb begin
    shifted_s = {rem_r, q_r[DIV_WIDTH-1]};
    take_s    = shifted_s[DIV_WIDTH] | no_borrow_s;
  end

  // Final result correction: divide-by-zero pattern or sign application.
  // Sign bits are stored already gated by is_signed, so divu passes through.
  always_comb begin
    fix_q_s = q_r;
    fix_r_s = rem_r;
    if (dz_r) begin
      fix_q_s = DIV_ZERO_QUOT;
      fix_r_s = raw_a_r;
    end else begin
      if (sign_a_r ^ sign_b_r) begin
        fix_q_s = neg2(q_r);
      end else begin
        fix_q_s = q_r;
      end
      if (sign_a_r) begin
        fix_r_s = neg2(rem_r);
      end else begin
        fix_r_s = rem_r;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == 5'd0) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= 5'd0;
      q_r         <= 32'd0;
      rem_r       <= 32'd0;
      dmag_r      <= 32'd0;
      raw_a_r     <= 32'd0;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      dz_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (start) begin
            sign_a_r    <= is_signed & dividend[DIV_WIDTH-1];
            sign_b_r    <= is_signed & divisor[DIV_WIDTH-1];
            q_r         <= mag(dividend, is_signed);
            dmag_r      <= mag(divisor, is_signed);
            raw_a_r     <= dividend;
            rem_r       <= 32'd0;
            cnt_r       <= 5'd31;
            dz_r        <= (divisor == 32'd0);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          rem_r <= take_s ? diff_s : shifted_s[DIV_WIDTH-1:0];
          q_r   <= {q_r[DIV_WIDTH-2:0], take_s};
          cnt_r <= cnt_r - 5'd1;
        end
        FIX: begin
          quotient    <= fix_q_s;
          remainder   <= fix_r_s;
          div_by_zero <= dz_r;
          busy        <= 1'b0;
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_divider.sv
// Directed self-checking bench for mips_divider.
module tb_mips_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int tests;
  int fails;

  mips_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it for 40 cycles after the accept edge.
  // Cycle n is the interval after accept edge + (n-1) edges. When ign is set,
  // a second request with other operands is held high in cycles 5 and 34.
  task automatic run_op(input string tag, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_dz, input logic ign);
    int done_cyc;
    int done_cnt;
    int busy_err;
    logic [31:0] q_at_done;
    logic [31:0] r_at_done;
    logic        dz_at_done;
    done_cyc   = -1;
    done_cnt   = 0;
    busy_err   = 0;
    q_at_done  = 32'hDEAD_BEEF;
    r_at_done  = 32'hDEAD_BEEF;
    dz_at_done = 1'bx;
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (busy !== ((cyc <= 33) ? 1'b1 : 1'b0)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc   = cyc;
          q_at_done  = quotient;
          r_at_done  = remainder;
          dz_at_done = div_by_zero;
        end
      end
      if (ign && (cyc == 5 || cyc == 34)) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd1;
        divisor   = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " latency"},   32'(done_cyc), 32'd34);
    check({tag, " done_cnt"},  32'(done_cnt), 32'd1);
    check({tag, " busy_win"},  32'(busy_err), 32'd0);
    check({tag, " quotient"},  q_at_done, exp_q);
    check({tag, " remainder"}, r_at_done, exp_r);
    check({tag, " dz"},        {31'd0, dz_at_done}, {31'd0, exp_dz});
    check({tag, " q_hold"},    quotient, exp_q);
  endtask

  initial begin
    int dcnt;
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst dz",   {31'd0, div_by_zero}, 32'd0);
    check("rst q",    quotient, 32'd0);
    check("rst r",    remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("divu100/7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0);
    run_op("div-7/2",      1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0);
    run_op("divu-7/2",     1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 1'b0);
    run_op("div7/-2",      1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0);
    run_op("div-8/-3",     1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE,  1'b0, 1'b0);
    run_op("div_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b0);
    run_op("divu_max/1",   1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0);
    run_op("div5/0",       1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1'b0);
    run_op("divu9/3",      1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 1'b0);
    run_op("ignore_start", 1'b0, 32'd50,         32'd6,          32'd8,          32'd2,          1'b0, 1'b1);

    // Reset in cycle 10 of a run: outputs clear at once and no done follows.
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'h0000_FFFF;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst busy", {31'd0, busy}, 32'd0);
    check("mid_rst q",    quotient, 32'd0);
    check("mid_rst r",    remainder, 32'd0);
    check("mid_rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("post_rst quiet", 32'(dcnt), 32'd0);

    run_op("divu1000/10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
